// File: rtl/shift_count_reg.sv
// shift_count_reg: WIDTH-bit register with clock enable and eight modes
// (hold, load, shift right/left, rotate right/left, count up/down).
// Optional feature macro: COUNT_MODE_EN enables the counting modes 6/7;
// when undefined those modes behave as hold.
module shift_count_reg #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInL,
  input  logic             SerInR,
  output logic [WIDTH-1:0] Q,
  output logic             Cout,
  output logic             Zero
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHR  = 3'd2,
    M_SHL  = 3'd3,
    M_ROR  = 3'd4,
    M_ROL  = 3'd5,
    M_UP   = 3'd6,
    M_DN   = 3'd7
  } mode_e;

  logic [WIDTH-1:0] q_nxt;
  logic             c_nxt;
  mode_e            mode;

  assign mode = mode_e'(Mode);

  // Next-state / shift-out selection for an enabled cycle.
  always_comb begin
    q_nxt = Q;
    c_nxt = 1'b0;
    case (mode)
      M_LOAD: q_nxt = D;
      M_SHR: begin
        q_nxt = {SerInL, Q[WIDTH-1:1]};
        c_nxt = Q[0];
      end
      M_SHL: begin
        q_nxt = {Q[WIDTH-2:0], SerInR};
        c_nxt = Q[WIDTH-1];
      end
      M_ROR: begin
        q_nxt = {Q[0], Q[WIDTH-1:1]};
        c_nxt = Q[0];
      end
      M_ROL: begin
        q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
        c_nxt = Q[WIDTH-1];
      end
`ifdef COUNT_MODE_EN
      M_UP: begin
        // Carry out of the WIDTH-bit increment is the wrap indicator.
        {c_nxt, q_nxt} = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
      end
      M_DN: begin
        q_nxt = Q - {{(WIDTH-1){1'b0}}, 1'b1};
        c_nxt = (Q == '0);
      end
`else
      M_UP, M_DN: begin
        q_nxt = Q;
        c_nxt = 1'b0;
      end
`endif
      default: begin
        q_nxt = Q;
        c_nxt = 1'b0;
      end
    endcase
  end

  // State register: reset beats enable; a disabled cycle holds Q and clears Cout.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Q    <= RESET_VALUE;
      Cout <= 1'b0;
    end else if (!E) begin
      Cout <= 1'b0;
    end else begin
      Q    <= q_nxt;
      Cout <= c_nxt;
    end
  end

  assign Zero = (Q == '0);

endmodule

// File: tb/tb_shift_count_reg.sv
// Directed self-checking bench for shift_count_reg (WIDTH=8, RESET_VALUE=8'hA5).
// Counting checks follow COUNT_MODE_EN the same way the design does.
module tb_shift_count_reg;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       E;
  logic [2:0] Mode;
  logic [7:0] D;
  logic       SerInL;
  logic       SerInR;
  logic [7:0] Q;
  logic       Cout;
  logic       Zero;

  int total = 0;
  int bad   = 0;

  shift_count_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .E      (E),
    .Mode   (Mode),
    .D      (D),
    .SerInL (SerInL),
    .SerInR (SerInR),
    .Q      (Q),
    .Cout   (Cout),
    .Zero   (Zero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [7:0] q, input logic c);
    chk({tag, ".q"}, 32'(Q), 32'(q));
    chk({tag, ".cout"}, 32'(Cout), 32'(c));
    chk({tag, ".zero"}, 32'(Zero), 32'(q == 8'h00));
  endtask

  task automatic load(input logic [7:0] v);
    E = 1'b1; Mode = 3'd1; D = v;
    step();
    expect_st("load", v, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; E = 1'b1; Mode = 3'd1; D = 8'h3C; SerInL = 1'b0; SerInR = 1'b0;
    #2;
    step();
    expect_st("reset", 8'hA5, 1'b0);
    Reset = 1'b1;
    step();
    expect_st("load_after_reset", 8'h3C, 1'b0);

    // shift right twice then shift left
    load(8'h81);
    Mode = 3'd2; SerInL = 1'b0;
    step(); expect_st("shr1", 8'h40, 1'b1);
    step(); expect_st("shr2", 8'h20, 1'b0);
    Mode = 3'd3; SerInR = 1'b1;
    step(); expect_st("shl1", 8'h41, 1'b0);

    // serial inputs with opposite polarity
    load(8'h81);
    Mode = 3'd2; SerInL = 1'b1;
    step(); expect_st("shr_ser1", 8'hC0, 1'b1);
    load(8'h81);
    Mode = 3'd3; SerInR = 1'b0;
    step(); expect_st("shl_ser0", 8'h02, 1'b1);

    // rotates
    load(8'h81);
    Mode = 3'd5;
    step(); expect_st("rol", 8'h03, 1'b1);
    Mode = 3'd4;
    step(); expect_st("ror", 8'h81, 1'b1);

    // E=0 freezes Q and clears the pending Cout pulse
    E = 1'b0; Mode = 3'd1; D = 8'h55;
    for (int i = 0; i < 4; i++) begin
      step(); expect_st("disabled", 8'h81, 1'b0);
    end

    // hold mode leaves Q and clears Cout
    E = 1'b1; Mode = 3'd4;
    step(); expect_st("ror2", 8'hC0, 1'b1);
    Mode = 3'd0;
    step(); expect_st("hold", 8'hC0, 1'b0);

    // zero flag
    load(8'h00);

`ifdef COUNT_MODE_EN
    load(8'hFE);
    Mode = 3'd6;
    step(); expect_st("up1", 8'hFF, 1'b0);
    step(); expect_st("up2", 8'h00, 1'b1);
    step(); expect_st("up3", 8'h01, 1'b0);
    Mode = 3'd7;
    step(); expect_st("dn1", 8'h00, 1'b0);
    step(); expect_st("dn2", 8'hFF, 1'b1);
`else
    load(8'h10);
    Mode = 3'd6;
    step(); expect_st("up_off", 8'h10, 1'b0);
    Mode = 3'd7;
    step(); expect_st("dn_off", 8'h10, 1'b0);
`endif

    // reset mid-count wins, then operation resumes from RESET_VALUE
    Reset = 1'b0; E = 1'b1; Mode = 3'd6;
    step(); expect_st("reset_mid", 8'hA5, 1'b0);
    Reset = 1'b1;
`ifdef COUNT_MODE_EN
    step(); expect_st("resume", 8'hA6, 1'b0);
`else
    step(); expect_st("resume", 8'hA5, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_count_reg.md
# shift_count_reg

Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit register with clock enable and eight operating modes. The modes are hold, parallel load, logical shift right/left with serial inputs, rotate right/left, and up/down count. It is the general-purpose storage, shift and count element for datapaths in this design. All state changes occur on the rising clock edge. Reset is synchronous and active-low.

## Interface
Parameters:
- WIDTH, default 8: register width in bits; legal range 2..32.
- RESET_VALUE, default 0: value loaded into Q by reset; WIDTH bits.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset (Reset=0 at a rising edge resets).
- E  input  1  clock enable; E=0 freezes Q regardless of Mode.
- Mode  input  3  operation select, see Operation.
- D  input  WIDTH  parallel load data.
- SerInL  input  1  bit entering Q[WIDTH-1] on shift right.
- SerInR  input  1  bit entering Q[0] on shift left.
- Q  output  WIDTH  registered state.
- Cout  output  1  registered shift-out / carry / borrow bit of the last operation.
- Zero  output  1  combinational; 1 when Q == 0.

## Operation
- Priority: Reset > E > Mode.
- Reset=0 at an edge: Q <= RESET_VALUE and Cout <= 0.
- E=0: Q holds and Cout <= 0.
- E=1, by Mode:
  - 0 hold: Q unchanged; Cout <= 0.
  - 1 load: Q <= D; Cout <= 0.
  - 2 shift right: Q <= {SerInL, Q[WIDTH-1:1]}; Cout <= old Q[0].
  - 3 shift left: Q <= {Q[WIDTH-2:0], SerInR}; Cout <= old Q[WIDTH-1].
  - 4 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}; Cout <= old Q[0].
  - 5 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; Cout <= old Q[WIDTH-1].
  - 6 count up: Q <= Q+1 modulo 2^WIDTH; Cout <= 1 only when old Q was all ones (wrap to 0).
  - 7 count down: Q <= Q-1 modulo 2^WIDTH; Cout <= 1 only when old Q was 0 (wrap to all ones).
- Cout is a one-cycle pulse. It is 0 in any cycle that does not produce a shift-out, carry or borrow.
- Arithmetic is unsigned, WIDTH bits, with no saturation.
- Serial inputs are sampled only in modes 2 and 3. D is sampled only in mode 1.

## Timing
- Latency: one cycle. The inputs at edge N determine Q and Cout after edge N.
- Zero follows Q combinationally with no added cycle.
- Reset values: Q = RESET_VALUE, Cout = 0, Zero = (RESET_VALUE == 0).
- Reset asserted mid-sequence (for example during counting) overrides at that edge. The operation resumes from RESET_VALUE on the first edge with Reset=1.
- Mode and E changes take effect at the next edge, with no pipeline state carried over.
- Back-to-back operations in any mode order are legal every cycle.
- Inputs are never sampled between edges; Q has no glitches.

## Configuration
- COUNT_MODE_EN defined: modes 6 and 7 count as specified above.
- COUNT_MODE_EN undefined: the incrementer and decrementer are omitted. Modes 6 and 7 act as hold (Q unchanged, Cout <= 0). All other modes are unaffected.

## Test plan
- Reset with RESET_VALUE=8'hA5, E=1, Mode=1, D=8'h3C: Q=8'hA5 and Cout=0 after the edge. Release reset and apply one edge: Q=8'h3C.
- Q=8'h81, Mode=2, SerInL=0, 2 edges: Q=8'h40 then 8'h20; Cout=1 then 0. Then Mode=3, SerInR=1, 1 edge: Q=8'h41, Cout=0.
- Q=8'h81, Mode=5 for 1 edge: Q=8'h03, Cout=1. Then Mode=4 for 1 edge: Q=8'h81, Cout=1.
- With COUNT_MODE_EN, Q=8'hFE, Mode=6, 3 edges: Q=FF (Cout=0), 00 (Cout=1, Zero=1), 01 (Cout=0). Then Mode=7 for 2 edges: Q=00 (Cout=0), FF (Cout=1).
- E=0 with Mode=1 and D=8'h55 for 4 edges: Q unchanged and Cout=0. Then Reset=0 together with E=1, Mode=6 for 1 edge: Q=RESET_VALUE.
- Without COUNT_MODE_EN, Q=8'h10, Mode=6 and then Mode=7, 1 edge each: Q stays 8'h10 and Cout=0.
